// File: rtl/flash_tick_gen.sv
// Programmable-period strobe generator feeding the LED flasher's i_valid.
// A registered rate select picks one of four periods; a rate change or stop restarts the timebase.
module flash_tick_gen #(
    parameter int unsigned NB_COUNTER = 32,
    parameter int unsigned LIMIT_0    = 25000000,
    parameter int unsigned LIMIT_1    = 50000000,
    parameter int unsigned LIMIT_2    = 100000000,
    parameter int unsigned LIMIT_3    = 200000000
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_sel,
    output logic       o_valid,
    output logic       o_running,
    output logic [1:0] o_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [NB_COUNTER-1:0]   counter_q, counter_d;
    logic [NB_COUNTER-1:0]   terminal;
    logic [1:0]              sel_q, sel_d;
    logic                    valid_q, valid_d;
    logic                    running_q, running_d;

    // Terminal count is derived from the registered select only, never from i_sel.
    always_comb begin
        terminal = NB_COUNTER'(LIMIT_0 - 1);
        case (sel_q)
            2'd0:    terminal = NB_COUNTER'(LIMIT_0 - 1);
            2'd1:    terminal = NB_COUNTER'(LIMIT_1 - 1);
            2'd2:    terminal = NB_COUNTER'(LIMIT_2 - 1);
            default: terminal = NB_COUNTER'(LIMIT_3 - 1);
        endcase
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            sel_q     <= 2'd0;
            valid_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        sel_d     = sel_q;
        valid_d   = 1'b0;
        running_d = running_q;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                running_d = 1'b0;
                sel_d     = i_sel;
                if (i_enable) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                end
            end
            RUN: begin
                running_d = 1'b1;
                // Stop wins over terminal count so a pulse is never issued on the stop edge.
                if (!i_enable) begin
                    state_d   = IDLE;
                    counter_d = '0;
                    running_d = 1'b0;
                end else if (i_sel != sel_q) begin
                    sel_d     = i_sel;
                    counter_d = '0;
                end else if (counter_q == terminal) begin
                    counter_d = '0;
                    valid_d   = 1'b1;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                counter_d = '0;
                running_d = 1'b0;
            end
        endcase
    end

    assign o_valid   = valid_q;
    assign o_running = running_q;
    assign o_sel     = sel_q;

endmodule

// File: tb/tb_flash_tick_gen.sv
// Bench for flash_tick_gen: pulse-schedule model checked every cycle plus directed
// literal expectations for period, restart, stop and reset behaviour.
module tb_flash_tick_gen;

    localparam int L0 = 4;
    localparam int L1 = 6;
    localparam int L2 = 8;
    localparam int L3 = 10;

    logic       clock;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_sel;
    logic       o_valid;
    logic       o_running;
    logic [1:0] o_sel;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;
    int pulse_log[$];
    logic [15:0] exp_q[$];

    // model state: scheduled edge of the next pulse instead of a counter
    bit   m_run;
    int   m_sel;
    int   m_deadline;
    logic exp_valid, exp_running;
    logic [1:0] exp_sel;
    logic prev_valid = 1'b0;
    logic [3:0] leds;

    flash_tick_gen #(
        .NB_COUNTER(8),
        .LIMIT_0(L0),
        .LIMIT_1(L1),
        .LIMIT_2(L2),
        .LIMIT_3(L3)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_sel(i_sel),
        .o_valid(o_valid),
        .o_running(o_running),
        .o_sel(o_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // stand-in for the downstream flasher, NB_LEDS=4
    always @(posedge clock or posedge i_reset) begin
        if (i_reset) leds <= 4'hF;
        else if (o_valid) leds <= ~leds;
    end

    function automatic int lim(input int s);
        case (s)
            0: return L0;
            1: return L1;
            2: return L2;
            default: return L3;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_step();
        exp_valid = 1'b0;
        if (i_reset) begin
            m_run = 0;
            m_sel = 0;
        end else if (!m_run) begin
            m_sel = int'(i_sel);
            if (i_enable) begin
                m_run = 1;
                m_deadline = edge_cnt + lim(m_sel);
            end
        end else if (!i_enable) begin
            m_run = 0;
        end else if (int'(i_sel) != m_sel) begin
            m_sel = int'(i_sel);
            m_deadline = edge_cnt + lim(m_sel);
        end else if (edge_cnt == m_deadline) begin
            exp_valid = 1'b1;
            m_deadline = edge_cnt + lim(m_sel);
        end
        exp_running = m_run;
        exp_sel = 2'(m_sel);
    endtask

    always @(posedge clock) begin
        edge_cnt++;
        model_step();
        #1;
        check("valid", int'(o_valid), int'(exp_valid));
        check("running", int'(o_running), int'(exp_running));
        check("sel", int'(o_sel), int'(exp_sel));
        if (o_valid) begin
            check("no_back_to_back", int'(prev_valid), 0);
            pulse_log.push_back(edge_cnt);
        end
        prev_valid = o_valid;
    end

    task automatic run_edges(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_pulses(input string name, input int base);
        check({name, "_count"}, pulse_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < pulse_log.size(); i++)
            check({name, "_offset"}, pulse_log[i] - base, int'(exp_q[i]));
    endtask

    initial begin
        int  e0;
        int  r;
        bit  found;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_sel    = 2'd0;
        #1;
        check("reset_valid", int'(o_valid), 0);
        check("reset_running", int'(o_running), 0);
        check("reset_sel", int'(o_sel), 0);
        run_edges(2);
        i_reset = 1'b0;

        // 1: reset in the middle of a pulse, then stay idle
        i_sel = 2'd1;
        i_enable = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clock);
            #2;
            if (o_valid) found = 1;
        end
        check("t1_pulse_seen", int'(found), 1);
        i_reset = 1'b1;
        #1;
        check("t1_async_valid", int'(o_valid), 0);
        check("t1_async_running", int'(o_running), 0);
        check("t1_async_sel", int'(o_sel), 0);
        @(negedge clock);
        i_enable = 1'b0;
        i_sel = 2'd0;
        @(negedge clock);
        i_reset = 1'b0;
        pulse_log.delete();
        run_edges(20);
        check("t1_idle_pulses", pulse_log.size(), 0);
        check("t1_idle_running", int'(o_running), 0);
        check("t1_idle_sel", int'(o_sel), 0);

        // 2: period 4 from enable
        i_sel = 2'd0;
        i_enable = 1'b1;
        e0 = edge_cnt + 1;
        pulse_log.delete();
        run_edges(1);
        check("t2_running_at_e0", int'(o_running), 1);
        run_edges(12);
        exp_q = {16'd4, 16'd8, 16'd12};
        check_pulses("t2", e0);

        // 3: rate change 2 -> 1 at counter 5
        i_enable = 1'b0;
        run_edges(2);
        i_sel = 2'd2;
        i_enable = 1'b1;
        run_edges(6);
        check("t3_sel_before", int'(o_sel), 2);
        i_sel = 2'd1;
        r = edge_cnt + 1;
        pulse_log.delete();
        run_edges(1);
        check("t3_sel_after", int'(o_sel), 1);
        run_edges(12);
        exp_q = {16'd6, 16'd12};
        check_pulses("t3", r);

        // 4: stop exactly on the terminal-count edge, then re-enable
        i_enable = 1'b0;
        i_sel = 2'd0;
        run_edges(2);
        i_enable = 1'b1;
        run_edges(4);
        i_enable = 1'b0;
        pulse_log.delete();
        run_edges(1);
        check("t4_stop_valid", int'(o_valid), 0);
        check("t4_stop_running", int'(o_running), 0);
        run_edges(5);
        check("t4_stop_pulses", pulse_log.size(), 0);
        i_enable = 1'b1;
        e0 = edge_cnt + 1;
        run_edges(5);
        exp_q = {16'd4};
        check_pulses("t4_reenable", e0);

        // 5: sweep all four rates, three pulses each
        i_enable = 1'b0;
        run_edges(2);
        for (int s = 0; s < 4; s++) begin
            int l;
            l = lim(s);
            i_sel = 2'(s);
            i_enable = 1'b1;
            r = edge_cnt + 1;
            pulse_log.delete();
            run_edges(3 * l + 1);
            exp_q = {16'(l), 16'(2 * l), 16'(3 * l)};
            check_pulses("t5", r);
            if (pulse_log.size() >= 2)
                check("t5_period", pulse_log[1] - pulse_log[0], l);
        end

        // 6: flasher chained, slowest rate
        @(negedge clock);
        i_reset = 1'b1;
        i_enable = 1'b0;
        i_sel = 2'd3;
        run_edges(1);
        i_reset = 1'b0;
        check("t6_leds_reset", int'(leds), 15);
        i_enable = 1'b1;
        run_edges(11);
        check("t6_leds_before", int'(leds), 15);
        run_edges(1);
        check("t6_leds_first", int'(leds), 0);
        run_edges(9);
        check("t6_leds_hold", int'(leds), 0);
        run_edges(1);
        check("t6_leds_second", int'(leds), 15);

        i_enable = 1'b0;
        run_edges(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
